// File: rtl/alu_frame_pkg.sv
// Shared types and constants for the ALU frame controller: FSM states,
// frame lengths and the layout of the response status byte.
package alu_frame_pkg;

  typedef enum logic [1:0] {
    ST_RECV = 2'd0,
    ST_EXEC = 2'd1,
    ST_SEND = 2'd2
  } state_e;

  localparam int FRAME_RX_BYTES = 5;
  localparam int FRAME_TX_BYTES = 5;
  localparam int ERR_BIT        = 5;
  localparam int FLAG_MSB       = 3;
  localparam int FLAG_LSB       = 0;

  function automatic logic [7:0] make_status(input logic err, input logic [3:0] flags);
    logic [7:0] s;
    s                    = 8'h00;
    s[ERR_BIT]           = err;
    s[FLAG_MSB:FLAG_LSB] = flags;
    return s;
  endfunction

endpackage

// File: rtl/alu_frame_ctrl_if.sv
// UART-side byte handshakes of the ALU frame controller; the controller
// uses the slave view, the UART side (or a bench) the master view.
interface alu_frame_ctrl_if;
  logic       rx_valid_i;
  logic       rx_ready_o;
  logic [7:0] rx_data_i;
  logic       tx_valid_o;
  logic       tx_ready_i;
  logic [7:0] tx_data_o;

  modport master (
    output rx_valid_i, rx_data_i, tx_ready_i,
    input  rx_ready_o, tx_valid_o, tx_data_o
  );

  modport slave (
    input  rx_valid_i, rx_data_i, tx_ready_i,
    output rx_ready_o, tx_valid_o, tx_data_o
  );
endinterface

// File: rtl/alu_frame_txser.sv
// Load-then-shift response serializer: emits the loaded word MSB byte first
// over a valid/ready handshake and pulses done on the final transfer.
module alu_frame_txser
  import alu_frame_pkg::*;
(
  input  logic                        clk_i,
  input  logic                        rst_n,
  input  logic                        load_i,
  input  logic [8*FRAME_TX_BYTES-1:0] data_i,
  input  logic                        ready_i,
  output logic                        valid_o,
  output logic [7:0]                  data_o,
  output logic                        done_o
);

  localparam int W = 8 * FRAME_TX_BYTES;
  localparam logic [2:0] LAST_IDX = 3'(FRAME_TX_BYTES - 1);

  logic [W-1:0] sh_q, sh_d;
  logic [2:0]   cnt_q, cnt_d;
  logic         valid_q, valid_d;
  logic         fire;
  logic         last;

  assign fire = valid_q & ready_i;
  assign last = (cnt_q == LAST_IDX);

  always_comb begin
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    valid_d = valid_q;
    if (load_i) begin
      sh_d    = data_i;
      cnt_d   = 3'd0;
      valid_d = 1'b1;
    end else if (fire) begin
      // Shifting zeros in leaves tx_data at 0 once the frame has drained.
      sh_d  = {sh_q[W-9:0], 8'h00};
      cnt_d = cnt_q + 3'd1;
      if (last) begin
        valid_d = 1'b0;
        cnt_d   = 3'd0;
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      sh_q    <= '0;
      cnt_q   <= 3'd0;
      valid_q <= 1'b0;
    end else begin
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      valid_q <= valid_d;
    end
  end

  assign valid_o = valid_q;
  assign data_o  = sh_q[W-1 -: 8];
  assign done_o  = fire & last;

endmodule

// File: rtl/alu_frame_ctrl.sv
// Command sequencer between UART byte handshakes and a combinational ALU:
// collects a 5-byte command, runs one ALU evaluation, returns 5 response bytes.
module alu_frame_ctrl
  import alu_frame_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1000000,
  parameter int unsigned OP_W           = 3
) (
  input  logic            clk_i,
  input  logic            rst_n,
  alu_frame_ctrl_if.slave uart,
  output logic [31:0]     alu_a_o,
  output logic [31:0]     alu_b_o,
  output logic [OP_W-1:0] alu_op_o,
  input  logic [31:0]     alu_result_i,
  input  logic [3:0]      alu_flags_i,
  output logic            busy_o,
  output logic            timeout_o
);

  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LIMIT =
    (TIMEOUT_CYCLES > 0) ? TMO_W'(TIMEOUT_CYCLES - 1) : '0;
  localparam logic [2:0] RX_LAST = 3'(FRAME_RX_BYTES - 1);
  localparam int RESP_W = 8 * FRAME_TX_BYTES;

  state_e            state_q, state_d;
  logic [2:0]        byte_cnt_q, byte_cnt_d;
  logic [31:0]       shreg_q, shreg_d;
  logic [31:0]       a_q, a_d;
  logic [31:0]       b_q, b_d;
  logic [OP_W-1:0]   op_q, op_d;
  logic              err_q, err_d;
  logic [RESP_W-1:0] resp_q, resp_d;
  logic              load_q, load_d;
  logic [TMO_W-1:0]  tmo_cnt_q, tmo_cnt_d;
  logic              timeout_q, timeout_d;

  logic              rx_fire;
  logic              tmo_hit;
  logic [2:0]        cur_cnt;
  logic              tx_done;

  assign rx_fire = uart.rx_valid_i & (state_q == ST_RECV);

  always_comb begin
    state_d    = state_q;
    byte_cnt_d = byte_cnt_q;
    shreg_d    = shreg_q;
    a_d        = a_q;
    b_d        = b_q;
    op_d       = op_q;
    err_d      = err_q;
    resp_d     = resp_q;
    load_d     = 1'b0;
    tmo_cnt_d  = tmo_cnt_q;
    timeout_d  = 1'b0;
    tmo_hit    = 1'b0;
    cur_cnt    = byte_cnt_q;

    case (state_q)
      ST_RECV: begin
        // The timeout fires independently of a coincident byte, which then
        // starts a fresh frame instead of extending the stale one.
        tmo_hit = (TIMEOUT_CYCLES != 0) && (byte_cnt_q != 3'd0) && (tmo_cnt_q == TMO_LIMIT);
        if (tmo_hit) begin
          cur_cnt    = 3'd0;
          byte_cnt_d = 3'd0;
          timeout_d  = 1'b1;
          tmo_cnt_d  = '0;
        end else if (rx_fire || (byte_cnt_q == 3'd0)) begin
          tmo_cnt_d = '0;
        end else begin
          tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
        end

        if (rx_fire) begin
          if (cur_cnt == RX_LAST) begin
            a_d        = {{16{shreg_q[31]}}, shreg_q[31:16]};
            b_d        = {{16{shreg_q[15]}}, shreg_q[15:0]};
            op_d       = uart.rx_data_i[OP_W-1:0];
            err_d      = ((uart.rx_data_i >> OP_W) != 8'h00);
            byte_cnt_d = 3'd0;
            state_d    = ST_EXEC;
          end else begin
            shreg_d    = {shreg_q[23:0], uart.rx_data_i};
            byte_cnt_d = cur_cnt + 3'd1;
          end
        end
      end

      ST_EXEC: begin
        if (err_q) begin
          resp_d = {32'h0000_0000, make_status(1'b1, 4'h0)};
        end else begin
          resp_d = {alu_result_i, make_status(1'b0, alu_flags_i)};
        end
        load_d  = 1'b1;
        state_d = ST_SEND;
      end

      ST_SEND: begin
        if (tx_done) begin
          state_d = ST_RECV;
        end
      end

      default: begin
        state_d    = ST_RECV;
        byte_cnt_d = 3'd0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_RECV;
      byte_cnt_q <= 3'd0;
      shreg_q    <= 32'h0;
      a_q        <= 32'h0;
      b_q        <= 32'h0;
      op_q       <= '0;
      err_q      <= 1'b0;
      resp_q     <= '0;
      load_q     <= 1'b0;
      tmo_cnt_q  <= '0;
      timeout_q  <= 1'b0;
    end else begin
      state_q    <= state_d;
      byte_cnt_q <= byte_cnt_d;
      shreg_q    <= shreg_d;
      a_q        <= a_d;
      b_q        <= b_d;
      op_q       <= op_d;
      err_q      <= err_d;
      resp_q     <= resp_d;
      load_q     <= load_d;
      tmo_cnt_q  <= tmo_cnt_d;
      timeout_q  <= timeout_d;
    end
  end

  alu_frame_txser u_txser (
    .clk_i   (clk_i),
    .rst_n   (rst_n),
    .load_i  (load_q),
    .data_i  (resp_q),
    .ready_i (uart.tx_ready_i),
    .valid_o (uart.tx_valid_o),
    .data_o  (uart.tx_data_o),
    .done_o  (tx_done)
  );

  assign uart.rx_ready_o = (state_q == ST_RECV);
  assign alu_a_o         = a_q;
  assign alu_b_o         = b_q;
  assign alu_op_o        = op_q;
  assign busy_o          = (state_q != ST_RECV);
  assign timeout_o       = timeout_q;

endmodule

// File: doc/alu_frame_ctrl.md
Name: alu_frame_ctrl

Overview:
- Byte-level command sequencer between the UART byte interface and the combinational 32-bit ALU.
- Collects a 5-byte command frame from the UART receive handshake: A[15:0], B[15:0], op.
- Sign-extends the operands, drives the ALU for one evaluation, then returns a 5-byte response to the UART transmit handshake: result MSB first, then a status byte.
- Replaces the FIFO-based glue; owns all ALU sequencing, frame timeout and illegal-op detection.

Parameters:
- TIMEOUT_CYCLES, 1000000: idle clocks allowed between bytes of a partial frame before it is discarded; 0 disables the timeout.
- OP_W, 3: width of the ALU op field.

Ports:
- clk_i  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- rx_valid_i  in  1  received byte valid
- rx_ready_o  out  1  controller accepts byte
- rx_data_i  in  8  received byte
- tx_valid_o  out  1  response byte valid
- tx_ready_i  in  1  UART transmitter accepts byte
- tx_data_o  out  8  response byte
- alu_a_o  out  32  sign-extended operand A
- alu_b_o  out  32  sign-extended operand B
- alu_op_o  out  OP_W  ALU op
- alu_result_i  in  32  ALU result
- alu_flags_i  in  4  {Z,C,N,V} from ALU
- busy_o  out  1  high outside IDLE/RECV
- timeout_o  out  1  one-cycle pulse when a partial frame is dropped

Behaviour:
- Reset (async, rst_n=0): state=RECV, byte_cnt=0, rx_ready_o=1, tx_valid_o=0, tx_data_o=0, alu_a_o=alu_b_o=0, alu_op_o=0, busy_o=0, timeout_o=0, timeout counter=0.
- Handshakes: a transfer occurs on a clock edge where valid&ready=1. tx_valid_o, once high, holds with tx_data_o stable until tx_ready_i=1. rx_ready_o=1 only in RECV.
- States: RECV -> EXEC -> SEND -> RECV.
- RECV:
  - byte_cnt 0..4; bytes in order A_hi, A_lo, B_hi, B_lo, op.
  - Bytes 0-3 go into a 32-bit shift register.
  - On the op-byte transfer: load alu_a_o={{16{A[15]}},A}, alu_b_o={{16{B[15]}},B}, alu_op_o=op[OP_W-1:0]; set err = (op[7:OP_W]!=0); go to EXEC.
- EXEC (one cycle): the ALU settles. At the end of the cycle, latch alu_result_i and alu_flags_i into the response register; go to SEND with send_cnt=0.
- SEND:
  - tx_valid_o=1 in the cycle after EXEC.
  - Op byte accepted at edge T → first tx_valid_o high from edge T+2.
  - Bytes in order: res[31:24], res[23:16], res[15:8], res[7:0], status={2'b00, err, 1'b0, Z,C,N,V}.
  - send_cnt advances on each tx transfer. The transfer of byte 4 deasserts tx_valid_o, clears byte_cnt and returns to RECV; rx_ready_o=1 the next cycle.
- Illegal op (err=1): the frame completes normally; result bytes are 0x00, flags=0, status bit5=1.
- Operand registers hold their values from frame load until the next op-byte transfer.
- Timeout:
  - Applies only in RECV with byte_cnt!=0. The counter increments on each cycle without a transfer and clears on a transfer.
  - On reaching TIMEOUT_CYCLES-1: byte_cnt=0, counter=0, timeout_o=1 for one cycle.
  - A byte arriving on the same edge as the timeout is taken as byte 0 of a new frame.
- rx_valid_i outside RECV is ignored (back-pressured via rx_ready_o=0).
- Reset mid-frame or mid-send: immediate return to reset values; the partial response is abandoned.

Decomposition:
- Shared package alu_frame_pkg: state enum (RECV, EXEC, SEND), FRAME_RX_BYTES=5, FRAME_TX_BYTES=5, status bit positions (ERR_BIT=5, flag bits 3:0).
- One natural sub-module: alu_frame_txser, a 40-bit load-then-shift serializer with valid/ready output and a done pulse.

Test Plan:
- ALU stub result=A+B, flags from stub: rx 00 05 00 03 00 → tx 00 00 00 08 then status 0x00; first tx_valid_o exactly 2 cycles after the op-byte transfer.
- Sign extension: rx FF FE 00 01 00 → alu_a_o=0xFFFFFFFE, alu_b_o=0x00000001; stub result 0xFFFFFFFF, N=1 → tx FF FF FF FF 02.
- Illegal op: rx 00 01 00 01 F8 → tx 00 00 00 00 20; the next frame is processed normally.
- tx back-pressure: tx_ready_i low for 7 cycles on each byte → tx_data_o stable while tx_valid_o=1, no bytes lost or duplicated, rx_ready_o=0 throughout SEND.
- Timeout, TIMEOUT_CYCLES=16: send 2 bytes, idle 16 cycles → one timeout_o pulse; then a full frame 00 02 00 02 00 → tx 00 00 00 04 00.
- Async reset asserted during SEND byte 2 → tx_valid_o drops immediately, rx_ready_o=1 after release; a following frame responds correctly.
